// File: rtl/sc_sched_pkg.sv
// Shared types and constants for the stochastic-computing multiply scheduler.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package sc_sched_pkg;

    // Lane LFSR geometry: 31-bit, shift-left, feedback from bits 27 and 30.
    localparam int LFSR_W = 31;
    localparam int TAP_A  = 27;
    localparam int TAP_B  = 30;

    // Per-lane reseed values, loaded at the start of every job.
    localparam logic [LFSR_W-1:0] SEED1 = 31'd1;
    localparam logic [LFSR_W-1:0] SEED2 = 31'd2;

    // Ones counter width and its ceiling (largest window is 128 bits).
    localparam int              CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'd128;

    // Shortest window; win_sel shifts this left by 0..3.
    localparam int BASE_WIN = 16;

    // Pipeline flush length after the last RUN cycle (compare + product stages).
    localparam int DRAIN_CYC = 2;

    // Operand packing: [3:0] = X, [7:4] = Y.
    localparam int PROB_W = 4;
    localparam int OP_W   = 2 * PROB_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    // Window length N in bits for a given win_sel (16, 32, 64, 128).
    function automatic logic [CNT_W-1:0] win_len(input logic [1:0] ws);
        return CNT_W'(BASE_WIN) << ws;
    endfunction

    // One step of the lane LFSR.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B]};
    endfunction

    // Normalise the ones-count to an 8-bit fraction. Every window maps
    // full scale (count == N) to 128 after the shift, which does not fit a
    // 0..255 fraction cleanly, so full scale is reported as 8'hFF; any
    // partial count shifts to at most 127 and needs no clamping.
    function automatic logic [CNT_W-1:0] scale_count(input logic [CNT_W-1:0] cnt,
                                                     input logic [1:0]       ws);
        logic [CNT_W-1:0] res;
        if (cnt == win_len(ws)) begin
            res = '1;
        end else begin
            res = cnt << (2'd3 - ws);
        end
        return res;
    endfunction

endpackage

// File: rtl/sc_mult_lane.sv
// Stochastic multiply lane: two LFSRs, comparators, XNOR product, ones counter.
// Latency: a sample taken in a count_en cycle reaches the counter 2 cycles later.
// Backpressure: none; the scheduler sequences seed_load/count_en and reads cnt.
module sc_mult_lane
    import sc_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,      // asynchronous, active-high
    input  logic              seed_load,  // reseed LFSRs, clear counter and pipeline
    input  logic              count_en,   // advance LFSRs and inject one sample
    input  logic [PROB_W-1:0] x,
    input  logic [PROB_W-1:0] y,
    output logic [CNT_W-1:0]  cnt
);

    logic [LFSR_W-1:0] lfsr1_q, lfsr1_d;
    logic [LFSR_W-1:0] lfsr2_q, lfsr2_d;
    logic              sn1_q, sn1_d;
    logic              sn2_q, sn2_d;
    logic              cmp_vld_q, cmp_vld_d;
    logic              prod_q, prod_d;
    logic              prod_vld_q, prod_vld_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // LFSR pair: reseed on load, otherwise step only while sampling.
    always_comb begin
        lfsr1_d = lfsr1_q;
        lfsr2_d = lfsr2_q;
        if (seed_load) begin
            lfsr1_d = SEED1;
            lfsr2_d = SEED2;
        end else if (count_en) begin
            lfsr1_d = lfsr_next(lfsr1_q);
            lfsr2_d = lfsr_next(lfsr2_q);
        end
    end

    // Stage 1: turn each probability into one stochastic bit.
    always_comb begin
        sn1_d     = (lfsr1_q[PROB_W-1:0] < x);
        sn2_d     = (lfsr2_q[PROB_W-1:0] < y);
        cmp_vld_d = count_en & ~seed_load;
    end

    // Stage 2: bipolar multiply is an XNOR of the two streams.
    always_comb begin
        prod_d     = ~(sn1_q ^ sn2_q);
        prod_vld_d = cmp_vld_q & ~seed_load;
    end

    // Ones counter; holds at its ceiling instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (seed_load) begin
            cnt_d = '0;
        end else if (prod_vld_q && prod_q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Lane state registers.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            lfsr1_q    <= SEED1;
            lfsr2_q    <= SEED2;
            sn1_q      <= 1'b0;
            sn2_q      <= 1'b0;
            cmp_vld_q  <= 1'b0;
            prod_q     <= 1'b0;
            prod_vld_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            lfsr1_q    <= lfsr1_d;
            lfsr2_q    <= lfsr2_d;
            sn1_q      <= sn1_d;
            sn2_q      <= sn2_d;
            cmp_vld_q  <= cmp_vld_d;
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
            cnt_q      <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/sc_mult_sched.sv
// Two-requester scheduler for a stochastic multiply lane (round-robin, or fixed priority with SC_SCHED_FIXED_PRIO_EN).
// Latency: result valid N+4 cycles after the accept cycle, N = 16 << win_sel.
// Backpressure: result held until res_ready; no new job is accepted until then.
module sc_mult_sched
    import sc_sched_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,      // asynchronous, active-high
    input  logic [1:0]      req_valid,
    input  logic [OP_W-1:0] req_op0,
    input  logic [OP_W-1:0] req_op1,
    output logic [1:0]      req_ready,
    input  logic [1:0]      win_sel,
    output logic            res_valid,
    output logic            res_id,
    output logic [CNT_W-1:0] res_data,
    input  logic            res_ready,
    output logic            busy
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;     // position within RUN or DRAIN
    logic [OP_W-1:0]  op_q, op_d;       // operands of the running job
    logic             id_q, id_d;       // owner of the running job
    logic [1:0]       ws_q, ws_d;       // window of the running job
    logic [1:0]       grant;
    logic             accept;
    logic             seed_load;
    logic             count_en;
    logic [CNT_W-1:0] lane_cnt;
    logic [CNT_W-1:0] last_run;

    // Final RUN index of the latched window.
    assign last_run = win_len(ws_q) - CNT_W'(1);
    assign accept   = |req_ready;

`ifdef SC_SCHED_FIXED_PRIO_EN
    // Strict priority: requester 0 always wins.
    always_comb begin
        grant = 2'b00;
        if (req_valid[0]) begin
            grant = 2'b01;
        end else if (req_valid[1]) begin
            grant = 2'b10;
        end
    end
`else
    logic rr_last_q, rr_last_d;         // requester granted most recently

    // Round-robin: on contention, grant the requester not granted last.
    always_comb begin
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        rr_last_d = rr_last_q;
        if (accept) begin
            rr_last_d = grant[1];
        end
    end

    // Pointer resets as if requester 1 went last, so requester 0 wins first.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rr_last_q <= 1'b1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_RUN;
            ST_RUN:   if (cyc_q == last_run) state_d = ST_DRAIN;
            ST_DRAIN: if (cyc_q == CNT_W'(DRAIN_CYC - 1)) state_d = ST_RESP;
            ST_RESP:  if (res_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: handshakes, lane controls and the result presentation.
    always_comb begin
        req_ready = 2'b00;
        seed_load = 1'b0;
        count_en  = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        busy      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                // Keep the accept strobe quiet while reset is held.
                if (!rst_n) begin
                    req_ready = grant;
                end
            end
            ST_LOAD:  seed_load = 1'b1;
            ST_RUN:   count_en  = 1'b1;
            ST_RESP: begin
                res_valid = 1'b1;
                res_data  = scale_count(lane_cnt, ws_q);
            end
            default: ;
        endcase
    end

    // Job capture on accept and the RUN/DRAIN cycle counter.
    always_comb begin
        cyc_d = cyc_q;
        op_d  = op_q;
        id_d  = id_q;
        ws_d  = ws_q;
        case (state_q)
            ST_IDLE: begin
                cyc_d = '0;
                if (accept) begin
                    op_d = req_ready[1] ? req_op1 : req_op0;
                    id_d = req_ready[1];
                    ws_d = win_sel;
                end
            end
            ST_RUN:   cyc_d = (cyc_q == last_run) ? '0 : cyc_q + CNT_W'(1);
            ST_DRAIN: cyc_d = cyc_q + CNT_W'(1);
            default:  cyc_d = '0;
        endcase
    end

    // Job and result registers.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cyc_q <= '0;
            op_q  <= '0;
            id_q  <= 1'b0;
            ws_q  <= 2'd0;
        end else begin
            cyc_q <= cyc_d;
            op_q  <= op_d;
            id_q  <= id_d;
            ws_q  <= ws_d;
        end
    end

    assign res_id = id_q;

    sc_mult_lane u_lane (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (seed_load),
        .count_en  (count_en),
        .x         (op_q[PROB_W-1:0]),
        .y         (op_q[OP_W-1:PROB_W]),
        .cnt       (lane_cnt)
    );

endmodule
